// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared definitions for the dbus UART receiver.
// Contents: receive FSM state encoding, register offsets (decoded from
// adr[3:2]) and the bit positions of the STATUS register fields.
package uart_rx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;

  localparam int ST_NE        = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_FERR      = 3;
  localparam int ST_COUNT_LSB = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO holding received bytes.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset (empties the FIFO)
//   push_i, din_i   write request and data
//   pop_i, dout_o   read request and head-of-queue data (combinational)
//   empty_o, full_o occupancy flags
//   count_o         number of stored entries (0..DEPTH)
// A push while full only succeeds when a pop happens on the same edge.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wptr_d = do_push ? wptr_q + (AW+1)'(1) : wptr_q;
  assign rptr_d = do_pop  ? rptr_q + (AW+1)'(1) : rptr_q;

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q[AW-1:0]] <= din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver on the SERV dbus with a receive FIFO.
// Ports:
//   wb_clk, wb_rst_n     clock, asynchronous active-low reset
//   wb_dbus_adr/dat/sel  bus address, write data, byte selects (unused)
//   wb_dbus_we/cyc       bus write enable and cycle
//   rdt, ack             read data (0 outside ack) and one-cycle acknowledge
//   rx                   asynchronous serial input, idle high
//   irq                  receive interrupt
// Registers (adr[3:2]): 0 DATA {valid,23'b0,byte} (read pops),
//   1 STATUS {count[14:8], ferr, ovf, full, not_empty} (write 1 clears ovf/ferr).
// Build option: define UART_RX_IRQ_EN to drive irq from a registered
// (not_empty | ovf | ferr); otherwise irq is constant 0.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int                AWIDTH     = 8,
  parameter logic [AWIDTH-1:0] ADDR       = 8'h60,
  parameter int                DIVIDE     = 278,
  parameter int                FIFO_DEPTH = 8
) (
  input  logic        wb_clk,
  input  logic        wb_rst_n,
  input  logic [31:0] wb_dbus_adr,
  input  logic [31:0] wb_dbus_dat,
  input  logic [3:0]  wb_dbus_sel,
  input  logic        wb_dbus_we,
  input  logic        wb_dbus_cyc,
  output logic [31:0] rdt,
  output logic        ack,
  input  logic        rx,
  output logic        irq
);

  localparam int CW   = $clog2(DIVIDE);
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;

  // Synchroniser plus one extra stage for falling-edge detection.
  logic rx_meta_q, rx_s_q, rx_prev_q;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

  rx_state_e   state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        tick, rx_push, frame_err;

  assign tick = (clk_cnt_q == '0);

  // The first sample is DIVIDE/2 clocks after entering START (mid start bit);
  // every later sample is a full DIVIDE after the previous one.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rx_push   = 1'b0;
    frame_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q && rx_prev_q) begin
          state_d   = START;
          clk_cnt_d = CW'(DIVIDE / 2 - 1);
        end
      end
      START: begin
        if (tick) begin
          clk_cnt_d = CW'(DIVIDE - 1);
          bit_cnt_d = '0;
          state_d   = rx_s_q ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          clk_cnt_d = CW'(DIVIDE - 1);
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          if (rx_s_q) begin
            rx_push = 1'b1;
          end else begin
            frame_err = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
    end
  end

  // Bus side
  logic            match, req, fifo_pop, status_wr;
  logic [1:0]      reg_sel;
  logic [7:0]      fifo_dout;
  logic            fifo_empty, fifo_full;
  logic [CNTW-1:0] fifo_count;
  logic [31:0]     rd_val;
  logic            ack_q;
  logic [31:0]     rdt_q;
  logic            ovf_q, ovf_d, ferr_q, ferr_d;

  assign match     = (wb_dbus_adr[31:32-AWIDTH] == ADDR);
  assign req       = wb_dbus_cyc && match && !ack_q;
  assign reg_sel   = wb_dbus_adr[3:2];
  assign fifo_pop  = req && !wb_dbus_we && (reg_sel == REG_DATA) && !fifo_empty;
  assign status_wr = req && wb_dbus_we && (reg_sel == REG_STATUS);

  uart_rx_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (wb_clk),
    .rst_ni (wb_rst_n),
    .push_i (rx_push),
    .pop_i  (fifo_pop),
    .din_i  (shift_q),
    .dout_o (fifo_dout),
    .empty_o(fifo_empty),
    .full_o (fifo_full),
    .count_o(fifo_count)
  );

  always_comb begin
    rd_val = '0;
    case (reg_sel)
      REG_DATA: begin
        if (!fifo_empty) begin
          rd_val = {1'b1, 23'b0, fifo_dout};
        end
      end
      REG_STATUS: begin
        rd_val[ST_NE]                 = !fifo_empty;
        rd_val[ST_FULL]               = fifo_full;
        rd_val[ST_OVF]                = ovf_q;
        rd_val[ST_FERR]               = ferr_q;
        rd_val[ST_COUNT_LSB +: 7]     = 7'(fifo_count);
      end
      default: rd_val = '0;
    endcase
  end

  // A new error event on the same edge as a clear wins, so it is not lost.
  always_comb begin
    ovf_d  = ovf_q;
    ferr_d = ferr_q;
    if (status_wr && wb_dbus_dat[ST_OVF]) begin
      ovf_d = 1'b0;
    end
    if (status_wr && wb_dbus_dat[ST_FERR]) begin
      ferr_d = 1'b0;
    end
    if (rx_push && fifo_full && !fifo_pop) begin
      ovf_d = 1'b1;
    end
    if (frame_err) begin
      ferr_d = 1'b1;
    end
  end

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      ack_q  <= 1'b0;
      rdt_q  <= '0;
      ovf_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      ack_q  <= req;
      rdt_q  <= (req && !wb_dbus_we) ? rd_val : '0;
      ovf_q  <= ovf_d;
      ferr_q <= ferr_d;
    end
  end

  assign ack = ack_q;
  assign rdt = rdt_q;

`ifdef UART_RX_IRQ_EN
  logic irq_q;
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= !fifo_empty || ovf_q || ferr_q;
    end
  end
  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  // Bits of the bus that carry no meaning for this device.
  logic unused;
  assign unused = ^{wb_dbus_sel, wb_dbus_dat[31:4], wb_dbus_dat[1:0],
                    wb_dbus_adr[31-AWIDTH:4], wb_dbus_adr[1:0]};

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;
  localparam int OP_RD = 0;
  localparam int OP_WR = 1;
  localparam int OP_TX = 2;
  localparam int OP_GL = 3;
`ifdef UART_RX_IRQ_EN
  localparam logic IRQ_EN = 1'b1;
`else
  localparam logic IRQ_EN = 1'b0;
`endif

  typedef struct {
    int          op;
    logic [1:0]  r;
    logic [31:0] d;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic        wb_clk = 1'b0;
  logic        wb_rst_n;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, cyc, rx;
  logic [31:0] rdt;
  logic        ack, irq;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vq[$];

  always #5 wb_clk = ~wb_clk;

  uart_rx #(
    .AWIDTH(8), .ADDR(8'h60), .DIVIDE(16), .FIFO_DEPTH(4)
  ) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_dbus_adr(adr), .wb_dbus_dat(dat),
    .wb_dbus_sel(sel), .wb_dbus_we(we), .wb_dbus_cyc(cyc),
    .rdt(rdt), .ack(ack), .rx(rx), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  task automatic bus_read(input logic [1:0] r, output logic [31:0] d, output logic a);
    @(negedge wb_clk);
    adr = 32'h6000_0000 | {28'h0, r, 2'b00};
    we  = 1'b0;
    cyc = 1'b1;
    @(negedge wb_clk);
    a   = ack;
    d   = rdt;
    cyc = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] r, input logic [31:0] v);
    @(negedge wb_clk);
    adr = 32'h6000_0000 | {28'h0, r, 2'b00};
    dat = v;
    we  = 1'b1;
    cyc = 1'b1;
    @(negedge wb_clk);
    cyc = 1'b0;
    we  = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fb;
    fb = {stop_bit, b, 1'b0};
    for (int k = 0; k < 160; k++) begin
      @(negedge wb_clk);
      rx = fb[k/16];
    end
    @(negedge wb_clk);
    rx = 1'b1;
    repeat (4) @(negedge wb_clk);
  endtask

  initial begin
    logic [31:0] d;
    logic        a;
    logic [9:0]  fb;

    wb_rst_n = 1'b0; rx = 1'b1; cyc = 1'b0; we = 1'b0;
    adr = '0; dat = '0; sel = 4'hf;
    repeat (3) @(negedge wb_clk);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_rdt", rdt, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    wb_rst_n = 1'b1;
    repeat (2) @(negedge wb_clk);

    // Table of bus/line transactions with hand-computed expectations.
    vq.push_back('{OP_RD, 2'd1, 32'h0,   32'h0000_0000, "status_reset"});
    vq.push_back('{OP_RD, 2'd0, 32'h0,   32'h0000_0000, "data_empty"});
    vq.push_back('{OP_TX, 2'd0, 32'h1A5, 32'h0,         "tx_a5"});
    vq.push_back('{OP_RD, 2'd1, 32'h0,   32'h0000_0101, "status_one"});
    vq.push_back('{OP_RD, 2'd0, 32'h0,   32'h8000_00A5, "data_a5"});
    vq.push_back('{OP_RD, 2'd1, 32'h0,   32'h0000_0000, "status_drained"});
    vq.push_back('{OP_GL, 2'd0, 32'd6,   32'h0,         "glitch6"});
    vq.push_back('{OP_RD, 2'd1, 32'h0,   32'h0000_0000, "status_glitch"});
    vq.push_back('{OP_TX, 2'd0, 32'h03C, 32'h0,         "tx_3c_badstop"});
    vq.push_back('{OP_RD, 2'd1, 32'h0,   32'h0000_0008, "status_ferr"});
    vq.push_back('{OP_WR, 2'd1, 32'h8,   32'h0,         "clr_ferr"});
    vq.push_back('{OP_RD, 2'd1, 32'h0,   32'h0000_0000, "status_ferr_clr"});
    for (int i = 1; i <= 5; i++)
      vq.push_back('{OP_TX, 2'd0, 32'h100 | 32'(i), 32'h0, $sformatf("tx_%02x", i)});
    vq.push_back('{OP_RD, 2'd1, 32'h0,   32'h0000_0407, "status_ovf"});
    for (int i = 1; i <= 4; i++)
      vq.push_back('{OP_RD, 2'd0, 32'h0, 32'h8000_0000 | 32'(i), $sformatf("data_%02x", i)});
    vq.push_back('{OP_RD, 2'd0, 32'h0,   32'h0000_0000, "data_after_ovf"});
    vq.push_back('{OP_RD, 2'd1, 32'h0,   32'h0000_0004, "status_ovf_sticky"});
    vq.push_back('{OP_WR, 2'd1, 32'h4,   32'h0,         "clr_ovf"});
    vq.push_back('{OP_WR, 2'd0, 32'hFF,  32'h0,         "wr_data_ignored"});
    vq.push_back('{OP_RD, 2'd1, 32'h0,   32'h0000_0000, "status_clean"});
    vq.push_back('{OP_RD, 2'd2, 32'h0,   32'h0000_0000, "reg2"});
    vq.push_back('{OP_RD, 2'd3, 32'h0,   32'h0000_0000, "reg3"});

    foreach (vq[i]) begin
      case (vq[i].op)
        OP_RD: begin
          bus_read(vq[i].r, d, a);
          check({vq[i].name, "_ack"}, {31'b0, a}, 32'd1);
          check(vq[i].name, d, vq[i].exp);
        end
        OP_WR: begin
          bus_write(vq[i].r, vq[i].d);
          $display("wr   %s", vq[i].name);
        end
        OP_TX: begin
          send_frame(vq[i].d[7:0], vq[i].d[8]);
          $display("tx   %s", vq[i].name);
        end
        default: begin
          @(negedge wb_clk);
          rx = 1'b0;
          repeat (vq[i].d) @(negedge wb_clk);
          rx = 1'b1;
          repeat (30) @(negedge wb_clk);
          $display("gl   %s", vq[i].name);
        end
      endcase
    end

    // Non-matching address must never be acknowledged.
    @(negedge wb_clk);
    adr = 32'h7000_0004; we = 1'b0; cyc = 1'b1;
    repeat (2) @(negedge wb_clk);
    check("nomatch_ack", {31'b0, ack}, 32'd0);
    cyc = 1'b0;

    // Fill the FIFO, then pop on the very edge that pushes the fifth byte.
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
    fb = {1'b1, 8'h15, 1'b0};
    for (int k = 0; k < 160; k++) begin
      @(negedge wb_clk);
      rx = fb[k/16];
      if (k == 154) begin
        adr = 32'h6000_0000; we = 1'b0; cyc = 1'b1;
      end
      if (k == 155) begin
        check("pushpop_ack", {31'b0, ack}, 32'd1);
        check("pushpop_rdt", rdt, 32'h8000_0011);
        cyc = 1'b0;
      end
    end
    @(negedge wb_clk);
    rx = 1'b1;
    repeat (4) @(negedge wb_clk);
    bus_read(2'd1, d, a);
    check("pushpop_status", d, 32'h0000_0403);
    for (int i = 0; i < 4; i++) begin
      bus_read(2'd0, d, a);
      check($sformatf("pushpop_data_%0d", i), d, 32'h8000_0012 + 32'(i));
    end
    bus_read(2'd0, d, a);
    check("pushpop_empty", d, 32'h0);

    // Reset in the middle of a frame, during an ack cycle.
    send_frame(8'h55, 1'b1);
    @(negedge wb_clk);
    check("pre_rst_irq", {31'b0, irq}, {31'b0, IRQ_EN});
    fb = {1'b1, 8'h99, 1'b0};
    for (int k = 0; k <= 88; k++) begin
      @(negedge wb_clk);
      rx = fb[k/16];
      if (k == 87) begin
        adr = 32'h6000_0004; we = 1'b0; cyc = 1'b1;
      end
    end
    check("midrst_ack_before", {31'b0, ack}, 32'd1);
    check("midrst_rdt_before", rdt, 32'h0000_0101);
    cyc = 1'b0;
    #2 wb_rst_n = 1'b0;
    #1;
    check("midrst_ack", {31'b0, ack}, 32'd0);
    check("midrst_rdt", rdt, 32'd0);
    check("midrst_irq", {31'b0, irq}, 32'd0);
    rx = 1'b1;
    @(negedge wb_clk);
    wb_rst_n = 1'b1;
    repeat (20) @(negedge wb_clk);
    bus_read(2'd1, d, a);
    check("postrst_status", d, 32'h0);

    // Full frame after reset; irq follows the stop sample by one cycle.
    fb = {1'b1, 8'h7E, 1'b0};
    for (int k = 0; k < 160; k++) begin
      @(negedge wb_clk);
      rx = fb[k/16];
      if (k == 154) check("irq_before_stop", {31'b0, irq}, 32'd0);
      if (k == 155) check("irq_at_stop", {31'b0, irq}, 32'd0);
      if (k == 156) check("irq_after_stop", {31'b0, irq}, {31'b0, IRQ_EN});
    end
    @(negedge wb_clk);
    rx = 1'b1;
    repeat (4) @(negedge wb_clk);
    bus_read(2'd0, d, a);
    check("data_7e", d, 32'h8000_007E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Byte-wide UART receiver on the SERV dbus, the receive counterpart of the existing `uart` transmitter. It deserialises 8N1 frames from an external RX pin, buffers received bytes in a small FIFO, and exposes data/status registers to the CPU. Its `rdt`/`ack` outputs are OR-ed into the dbus return path with the other peripherals. An optional interrupt feeds `irq_reg`.

## Interface
Parameters:
- `ADDR`, 8'h60: device select value compared against `wb_dbus_adr[31:32-AWIDTH]`.
- `AWIDTH`, 8: number of address MSBs decoded.
- `DIVIDE`, 278: clocks per bit (278 gives 115200 baud at 32 MHz). Minimum 8.
- `FIFO_DEPTH`, 8: receive FIFO depth in bytes; power of 2, range 2..64.

Ports:
- `wb_clk` in 1: single clock.
- `wb_rst_n` in 1: reset, asynchronous, active-low.
- `wb_dbus_adr` in 32: dbus address.
- `wb_dbus_dat` in 32: write data.
- `wb_dbus_sel` in 4: byte selects; ignored.
- `wb_dbus_we` in 1: write enable.
- `wb_dbus_cyc` in 1: bus cycle.
- `rdt` out 32: read data; 0 whenever `ack` is low.
- `ack` out 1: single-cycle acknowledge.
- `rx` in 1: serial input; asynchronous, idle high.
- `irq` out 1: receive interrupt (see Configuration).

## Operation
- **Synchroniser:** `rx` passes through 2 flops, both reset to 1, giving `rx_s`.
- **FSM states:**
  - IDLE → START when `rx_s` is 0 and the previous `rx_s` was 1.
  - START: counts DIVIDE/2 clocks (integer divide), then samples. If `rx_s`=1 it is a false start and returns to IDLE. Otherwise it goes to DATA.
  - DATA: samples every DIVIDE clocks, 8 bits, LSB first, into a shift register.
  - STOP: samples after DIVIDE clocks. If 1, the byte is pushed to the FIFO. If 0, the byte is discarded, sticky `ferr` is set, and the FSM returns to IDLE. A new start is detected only after a 1→0 edge.
- **Bit counter:** 3 bits. **Clock counter:** `$clog2(DIVIDE)` bits, reloaded at each sample.
- **Registers** (decoded from `wb_dbus_adr[3:2]`):
  - 0 DATA (read): `{valid, 23'b0, byte}`. When non-empty, returns the FIFO head with valid=1 and pops it. When empty, returns 0 and does not pop. Writes are ignored.
  - 1 STATUS (read): bit0 not_empty, bit1 full, bit2 ovf, bit3 ferr, bits[14:8] count. A write with `dat[2]`=1 clears ovf; a write with `dat[3]`=1 clears ferr.
  - 2, 3: read 0, writes ignored.
- **Overflow:** a push while full drops the new byte, sets ovf, and leaves FIFO contents intact.
- **Push and pop in the same cycle:** count is unchanged. A push when full with a simultaneous pop succeeds, and ovf is not set.

## Timing
- Reset values: `ack`=0, `rdt`=0, `irq`=0, FSM=IDLE, FIFO empty, ovf=ferr=0.
- Bus: `ack` is asserted one cycle after `cyc`&match, for exactly one cycle (`ack <= cyc & match & !ack`). `rdt` is valid only in the `ack` cycle. The pop and the flag clears take effect on that same edge.
- Sample point: a data bit is sampled DIVIDE/2 + 1 + n·DIVIDE clocks after the falling edge of `rx_s` (n = 1..8). The stop bit is at n = 9. Add 2 cycles of synchroniser latency from the pin.
- FIFO push occurs on the stop-sample edge. `not_empty` and `irq` are visible on the next cycle.
- Assertion of `wb_rst_n` mid-frame aborts the frame and empties the FIFO immediately (asynchronously).

## Configuration
- `UART_RX_IRQ_EN` defined: `irq` is a registered copy of (not_empty | ovf | ferr).
- Not defined: `irq` is tied to 0, and no interrupt logic is built.

## Structure
- Package `uart_rx_pkg` contains:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - register offsets (REG_DATA=0, REG_STATUS=1);
  - status bit positions (ST_NE, ST_FULL, ST_OVF, ST_FERR, ST_COUNT_LSB=8).
- Sub-module `uart_rx_fifo`: synchronous FIFO with parameters WIDTH=8 and DEPTH, ports push/pop/din/dout/empty/full/count. It uses wrap-around pointers with one extra bit for the full/empty distinction.

## Test plan
All scenarios use DIVIDE=16 and FIFO_DEPTH=4.
- **Single byte:** drive frame 0xA5 → STATUS reads 0x0000_0101; DATA reads 0x8000_00A5; STATUS then reads 0x0000_0000.
- **False start:** drive a 6-clock low glitch → FSM returns to IDLE; STATUS count stays 0; ferr stays 0.
- **Framing error:** send 0x3C with stop=0 → no push; STATUS bit3=1; writing 0x8 to STATUS clears it.
- **Overflow:** send 0x01..0x05 with no reads → STATUS reads full=1, ovf=1, count=4; DATA reads 0x01, 0x02, 0x03, 0x04, then 0x0000_0000.
- **Simultaneous push/pop at full:** time a DATA read on the stop-sample edge → count stays 4; ovf stays 0; bytes are read in order.
- **Reset mid-frame, with `UART_RX_IRQ_EN`:** assert `wb_rst_n`=0 during bit 4 → `irq`, `ack` and count go to 0 immediately; the next full frame 0x7E is received correctly and `irq` rises 1 cycle after its stop sample.
